// File: rtl/sift_pkg.sv
// Shared scanner definitions: FSM states, 3x3 neighbourhood offsets, BRAM latency.
package sift_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    DECIDE = 3'd3,
    EMIT   = 3'd4,
    FINISH = 3'd5
  } scanner_state;

  localparam int NEIGH_CNT = 9;

  // k = 0 is the centre, k = 1..8 walk the ring in raster order.
  localparam int NEIGH_DX [NEIGH_CNT] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
  localparam int NEIGH_DY [NEIGH_CNT] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};

  localparam int BRAM_READ_LATENCY = 2;

endpackage

// File: rtl/extrema_accumulator.sv
// Running strict-extremum test of one centre sample against its 3x3x2 neighbourhood.
// The centre (k = 0) arrives first and seeds the flags with the layer-2 centre
// compare; every later sample can only clear them.
module extrema_accumulator
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 9
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        clear,
  input  logic                        sample_valid,
  input  logic signed [BIT_DEPTH-1:0] sample_first,
  input  logic signed [BIT_DEPTH-1:0] sample_second,
  input  logic                        is_centre,
  output logic                        is_max,
  output logic                        is_min,
  output logic        [BIT_DEPTH:0]   abs_centre
);

  logic signed [BIT_DEPTH-1:0] centre;
  logic signed [BIT_DEPTH-1:0] ref_val;
  logic                        max_ok, min_ok;
  logic                        gt_first, lt_first, gt_second, lt_second;
  logic        [BIT_DEPTH:0]   centre_ext;

  // Compare against the incoming centre on its own capture cycle, else the stored one.
  always_comb begin
    ref_val   = is_centre ? sample_first : centre;
    gt_first  = ref_val > sample_first;
    lt_first  = ref_val < sample_first;
    gt_second = ref_val > sample_second;
    lt_second = ref_val < sample_second;
  end

  // Magnitude in one extra bit so the most negative sample stays representable.
  always_comb begin
    centre_ext = {centre[BIT_DEPTH-1], centre};
    abs_centre = centre_ext[BIT_DEPTH] ? -centre_ext : centre_ext;
  end

  // Seed on the centre sample, then AND in each neighbour's strict compare.
  always_ff @(posedge clk) begin
    if (!rst_in || clear) begin
      centre <= '0;
      max_ok <= 1'b0;
      min_ok <= 1'b0;
    end else if (sample_valid) begin
      if (is_centre) begin
        centre <= sample_first;
        max_ok <= gt_second;
        min_ok <= lt_second;
      end else begin
        max_ok <= max_ok & gt_first & gt_second;
        min_ok <= min_ok & lt_first & lt_second;
      end
    end
  end

  assign is_max = max_ok;
  assign is_min = min_ok;

endmodule

// File: rtl/extrema_scanner.sv
// Full-frame DoG extremum scanner: walks interior pixels, reads each 3x3
// neighbourhood from two BRAM layers and emits keypoints over valid/ready.
module extrema_scanner
  import sift_pkg::*;
#(
  parameter  int BIT_DEPTH       = 9,
  parameter  int DIMENSION       = 4,
  parameter  int CONTRAST_THRESH = 0,
  localparam int AW              = $clog2(DIMENSION * DIMENSION),
  localparam int CW              = $clog2(DIMENSION)
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        start,
  output logic        [AW-1:0]        first_address,
  input  logic signed [BIT_DEPTH-1:0] first_data,
  output logic        [AW-1:0]        second_address,
  input  logic signed [BIT_DEPTH-1:0] second_data,
  output logic                        kp_valid,
  input  logic                        kp_ready,
  output logic        [CW-1:0]        kp_x,
  output logic        [CW-1:0]        kp_y,
  output logic                        kp_is_max,
  output logic                        busy,
  output logic                        done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(DIMENSION - 2);

  scanner_state  state;
  logic [CW-1:0] x, y;
  logic [CW-1:0] next_x, next_y;
  scanner_state  adv_state;
  logic [3:0]    k;
  int            addr_i;

  logic                         issue, issue_centre;
  logic [BRAM_READ_LATENCY:1]   vld_pipe, ctr_pipe;
  logic                         is_max, is_min, keypoint;
  logic [BIT_DEPTH:0]           abs_centre;

  // Read address for offset k of the current pixel; parked at 0 outside FETCH.
  always_comb begin
    addr_i = 0;
    if (state == FETCH)
      addr_i = (int'(y) + NEIGH_DY[k]) * DIMENSION + int'(x) + NEIGH_DX[k];
    first_address  = AW'(addr_i);
    second_address = AW'(addr_i);
  end

  assign issue        = (state == FETCH);
  assign issue_centre = (state == FETCH) && (k == 4'd0);

  // Valid/centre tags ride alongside the BRAM latency so capture ignores state.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      vld_pipe <= '0;
      ctr_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[BRAM_READ_LATENCY-1:1], issue};
      ctr_pipe <= {ctr_pipe[BRAM_READ_LATENCY-1:1], issue_centre};
    end
  end

  extrema_accumulator #(
    .BIT_DEPTH (BIT_DEPTH)
  ) u_acc (
    .clk           (clk),
    .rst_in        (rst_in),
    .clear         (state == IDLE),
    .sample_valid  (vld_pipe[BRAM_READ_LATENCY]),
    .sample_first  (first_data),
    .sample_second (second_data),
    .is_centre     (ctr_pipe[BRAM_READ_LATENCY]),
    .is_max        (is_max),
    .is_min        (is_min),
    .abs_centre    (abs_centre)
  );

  assign keypoint = (is_max | is_min) && (int'(abs_centre) > CONTRAST_THRESH);

  // Raster advance over the interior; leaving the last row ends the scan.
  always_comb begin
    next_x    = x + CW'(1);
    next_y    = y;
    adv_state = FETCH;
    if (x == LAST_IDX) begin
      next_x = CW'(1);
      if (y == LAST_IDX) adv_state = FINISH;
      else               next_y    = y + CW'(1);
    end
  end

  // Main scan FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      kp_valid  <= 1'b0;
      kp_is_max <= 1'b0;
      kp_x      <= '0;
      kp_y      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (DIMENSION < 3) begin
              done <= 1'b1;
            end else begin
              x     <= CW'(1);
              y     <= CW'(1);
              k     <= '0;
              busy  <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (k == 4'd8) begin
            k     <= '0;
            state <= DRAIN;
          end else begin
            k <= k + 4'd1;
          end
        end
        DRAIN: begin
          if (k == 4'd1) begin
            k     <= '0;
            state <= DECIDE;
          end else begin
            k <= k + 4'd1;
          end
        end
        DECIDE: begin
          if (keypoint) begin
            kp_valid  <= 1'b1;
            kp_x      <= x;
            kp_y      <= y;
            kp_is_max <= is_max;
            state     <= EMIT;
          end else begin
            x     <= next_x;
            y     <= next_y;
            state <= adv_state;
          end
        end
        EMIT: begin
          if (kp_ready) begin
            kp_valid <= 1'b0;
            x        <= next_x;
            y        <= next_y;
            state    <= adv_state;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extrema_scanner.sv
// Directed + randomized bench for extrema_scanner with a 2-cycle BRAM model.
// Two instances: index 0 with CONTRAST_THRESH = 0, index 1 with 50.
module tb_extrema_scanner;

  localparam int BD  = 9;
  localparam int DIM = 4;
  localparam int AW  = 4;
  localparam int CW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, start_drv, kp_ready_drv;
  int   sel;

  logic signed [BD-1:0] m1 [DIM*DIM];
  logic signed [BD-1:0] m2 [DIM*DIM];

  logic        [AW-1:0] fa [2];
  logic        [AW-1:0] sa [2];
  logic signed [BD-1:0] p1a [2], p1b [2], p2a [2], p2b [2];
  logic                 kv [2], kmax [2], bz [2], dn [2];
  logic        [CW-1:0] kx [2], ky [2];

  // Two-stage read pipe per instance: data shows two cycles after its address.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      p1a[i] <= m1[fa[i]];
      p1b[i] <= p1a[i];
      p2a[i] <= m2[sa[i]];
      p2b[i] <= p2a[i];
    end
  end

  extrema_scanner #(.BIT_DEPTH(BD), .DIMENSION(DIM), .CONTRAST_THRESH(0)) dut0 (
    .clk(clk), .rst_in(rst_in), .start(start_drv && (sel == 0)),
    .first_address(fa[0]), .first_data(p1b[0]),
    .second_address(sa[0]), .second_data(p2b[0]),
    .kp_valid(kv[0]), .kp_ready(kp_ready_drv), .kp_x(kx[0]), .kp_y(ky[0]),
    .kp_is_max(kmax[0]), .busy(bz[0]), .done(dn[0])
  );

  extrema_scanner #(.BIT_DEPTH(BD), .DIMENSION(DIM), .CONTRAST_THRESH(50)) dut1 (
    .clk(clk), .rst_in(rst_in), .start(start_drv && (sel == 1)),
    .first_address(fa[1]), .first_data(p1b[1]),
    .second_address(sa[1]), .second_data(p2b[1]),
    .kp_valid(kv[1]), .kp_ready(kp_ready_drv), .kp_x(kx[1]), .kp_y(ky[1]),
    .kp_is_max(kmax[1]), .busy(bz[1]), .done(dn[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: expected keypoints of the current frame, in raster order.
  typedef struct { int x; int y; int mx; } kp_t;
  kp_t exp_q[$];

  function automatic void build_exp(input int th);
    int c, n1, n2, mx, mn, a;
    exp_q.delete();
    for (int y = 1; y <= DIM - 2; y++)
      for (int x = 1; x <= DIM - 2; x++) begin
        c  = int'(m1[y*DIM + x]);
        mx = 1;
        mn = 1;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            n1 = int'(m1[(y+dy)*DIM + x + dx]);
            n2 = int'(m2[(y+dy)*DIM + x + dx]);
            if (!(dx == 0 && dy == 0)) begin
              if (!(c > n1)) mx = 0;
              if (!(c < n1)) mn = 0;
            end
            if (!(c > n2)) mx = 0;
            if (!(c < n2)) mn = 0;
          end
        a = (c < 0) ? -c : c;
        if ((mx || mn) && a > th) exp_q.push_back('{x, y, mx});
      end
  endfunction

  task automatic fill(input int v1, input int v2);
    for (int i = 0; i < DIM*DIM; i++) begin
      m1[i] = BD'(v1);
      m2[i] = BD'(v2);
    end
  endtask

  task automatic set1(input int x, input int y, input int v);
    m1[y*DIM + x] = BD'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(tag, {bz[0], dn[0], kv[0], kmax[0], fa[0], sa[0], kx[0], ky[0]}, 0);
  endtask

  // One full scan of the current frame on instance d; checks every handover.
  task automatic scan(input int d, input int stall, input bit restart);
    int  busy_cnt, got, vcnt, addr_bad;
    bit  fin;
    kp_t held;
    busy_cnt = 0; got = 0; vcnt = 0; addr_bad = 0; fin = 0;
    held = '{0, 0, 0};
    build_exp(d == 1 ? 50 : 0);
    sel = d;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    chk("first_addr", 32'(fa[d]), 5);
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (bz[d]) busy_cnt++;
      if (fa[d] !== sa[d]) addr_bad++;
      start_drv = restart && (cyc == 20);
      if (kv[d]) begin
        vcnt++;
        if (vcnt == 1) begin
          held = '{int'(kx[d]), int'(ky[d]), int'(kmax[d])};
          if (got < exp_q.size()) begin
            chk("kp_x", 32'(kx[d]), 32'(exp_q[got].x));
            chk("kp_y", 32'(ky[d]), 32'(exp_q[got].y));
            chk("kp_is_max", 32'(kmax[d]), 32'(exp_q[got].mx));
          end else begin
            chk("extra_kp", 32'(got), 32'(exp_q.size()));
          end
        end else begin
          chk("kp_stable", {kx[d], ky[d], kmax[d]}, {CW'(held.x), CW'(held.y), 1'(held.mx)});
        end
        kp_ready_drv = (vcnt > stall);
        if (kp_ready_drv) begin
          got++;
          vcnt = 0;
        end
      end else begin
        kp_ready_drv = 1'($urandom_range(0, 1));
        vcnt = 0;
      end
      if (dn[d]) begin
        chk("busy_at_done", 32'(bz[d]), 0);
        fin = 1;
      end
      tick();
    end
    start_drv = 1'b0;
    kp_ready_drv = 1'b0;
    chk("done_seen", 32'(fin), 1);
    chk("done_one_cycle", 32'(dn[d]), 0);
    chk("kp_count", 32'(got), 32'(exp_q.size()));
    chk("busy_cycles", 32'(busy_cnt), 32'(49 + exp_q.size() * (stall + 1)));
    chk("addr_equal", 32'(addr_bad), 0);
  endtask

  initial begin
    rst_in = 1'b0;
    start_drv = 1'b0;
    kp_ready_drv = 1'b0;
    sel = 0;
    fill(0, 0);
    repeat (3) tick();
    check_idle_outputs("reset_state");
    rst_in = 1'b1;
    tick();

    // All-zero frame, with a second start mid-scan that must be ignored.
    fill(0, 0);
    scan(0, 0, 1);

    // Strict maximum at (1,1).
    fill(5, 5);
    set1(1, 1, 100);
    scan(0, 2, 0);

    // Strict minimum at (2,2).
    fill(0, 0);
    set1(2, 2, -200);
    scan(0, 0, 0);

    // Tie with the layer-2 centre kills the maximum.
    fill(5, 5);
    set1(1, 1, 100);
    m2[1*DIM + 1] = BD'(100);
    scan(0, 0, 0);

    // Most negative sample is a valid minimum (magnitude must not overflow).
    fill(0, 0);
    set1(1, 2, -256);
    scan(0, 1, 0);

    // Two keypoints back to back, each held 10 cycles before acceptance.
    fill(0, 0);
    set1(1, 1, 100);
    set1(2, 1, -100);
    scan(0, 10, 0);

    // Contrast threshold 50: 40 rejected, 60 accepted.
    fill(0, 0);
    set1(1, 1, 40);
    scan(1, 0, 0);
    fill(0, 0);
    set1(1, 1, 60);
    scan(1, 3, 0);

    // Random frames with random spikes and random stalls.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < DIM*DIM; i++) begin
        m1[i] = BD'(int'($urandom_range(0, 40)) - 20);
        m2[i] = BD'(int'($urandom_range(0, 40)) - 20);
      end
      for (int y = 1; y <= DIM - 2; y++)
        for (int x = 1; x <= DIM - 2; x++)
          if ($urandom_range(0, 1) == 1)
            set1(x, y, ($urandom_range(0, 1) == 1) ? int'($urandom_range(30, 250))
                                                   : -int'($urandom_range(30, 255)));
      scan(0, int'($urandom_range(0, 4)), 0);
    end

    // Reset in the middle of FETCH abandons the pixel; a fresh start rescans.
    fill(5, 5);
    set1(1, 1, 100);
    sel = 0;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    repeat (4) tick();
    rst_in = 1'b0;
    tick();
    check_idle_outputs("reset_mid_fetch");
    rst_in = 1'b1;
    tick();
    check_idle_outputs("idle_after_reset");
    scan(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
